// File: rtl/spi_rd_master_pkg.sv
// Shared types and constants for the SPI protected-ROM read initiator.
package spi_rd_pkg;

    typedef enum logic [1:0] {IDLE, FLUSH, SHIFT, DONE} state_t;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;
    localparam int ERR_W  = 5;
    localparam int RX_W   = DATA_W + ERR_W;

    localparam int N_EDGES         = 29;
    localparam int ADDR_FIRST_EDGE = 2;
    localparam int DATA_FIRST_EDGE = 9;

endpackage

// File: rtl/spi_rd_master_if.sv
// Request/response port of the SPI read initiator.
interface spi_rd_master_if;

    logic                          req_valid;
    logic                          req_ready;
    logic [spi_rd_pkg::ADDR_W-1:0] req_addr;
    logic                          rsp_valid;
    logic [spi_rd_pkg::DATA_W-1:0] rsp_data;
    logic [spi_rd_pkg::ERR_W-1:0]  rsp_err_idx;
    logic                          rsp_err;
    logic                          busy;

    // master = requester, slave = the SPI initiator serving requests
    modport master (output req_valid, req_addr,
                    input  req_ready, rsp_valid, rsp_data, rsp_err_idx, rsp_err, busy);
    modport slave  (input  req_valid, req_addr,
                    output req_ready, rsp_valid, rsp_data, rsp_err_idx, rsp_err, busy);

endinterface

// File: rtl/spi_rd_master_sck_div.sv
// sck half-period divider: CLK_DIV cycles per phase, ticks mark the clk edge
// on which sck should rise or fall.
module spi_sck_div #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic rise,
    output logic fall,
    output logic pre_fall
);

    logic [7:0] cnt;
    logic       phase;    // 0 = low half, 1 = high half
    logic       tick;

    assign tick     = en && (cnt == 8'(CLK_DIV - 1));
    assign rise     = tick && !phase;
    assign fall     = tick && phase;
    // one cycle ahead of fall, lets the caller end a high phase early
    assign pre_fall = en && phase && (cnt == 8'(CLK_DIV - 2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (clr) begin
            cnt   <= '0;
            phase <= 1'b0;
        end else if (en) begin
            if (tick) begin
                cnt   <= '0;
                phase <= ~phase;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/spi_rd_master.sv
// SPI mode-0 initiator: one flush edge with cs_n high, then 29 edges that
// send a 5-bit address and receive 16 data bits plus a 5-bit error index.
module spi_rd_master
    import spi_rd_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    spi_rd_master_if.slave     rif,
    output logic               sck,
    output logic               cs_n,
    output logic               mosi,
    input  logic               miso
);

    state_t              state;
    logic                req_ready;
    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_data;
    logic [ERR_W-1:0]    rsp_err_idx;
    logic                rsp_err;
    logic [ADDR_W-1:0]   addr_sh;
    logic [RX_W-1:0]     rx;
    logic [4:0]          ecnt;
    logic                rise, fall, pre_fall;

    spi_sck_div #(.CLK_DIV(CLK_DIV)) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (state == FLUSH || state == SHIFT),
        .clr      (state == IDLE),
        .rise     (rise),
        .fall     (fall),
        .pre_fall (pre_fall)
    );

    assign rif.req_ready   = req_ready;
    assign rif.busy        = ~req_ready;
    assign rif.rsp_valid   = rsp_valid;
    assign rif.rsp_data    = rsp_data;
    assign rif.rsp_err_idx = rsp_err_idx;
    assign rif.rsp_err     = rsp_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_ready   <= 1'b1;
            cs_n        <= 1'b1;
            sck         <= 1'b0;
            mosi        <= 1'b0;
            addr_sh     <= '0;
            rx          <= '0;
            ecnt        <= '0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err_idx <= '0;
            rsp_err     <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rif.req_valid) begin
                        addr_sh   <= rif.req_addr;
                        ecnt      <= '0;
                        req_ready <= 1'b0;
                        state     <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (rise) sck <= 1'b1;
                    if (fall) begin
                        sck   <= 1'b0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // cs_n drops one cycle after sck fell, never on an sck edge
                    if (cs_n) cs_n <= 1'b0;
                    if (rise) begin
                        sck  <= 1'b1;
                        ecnt <= ecnt + 5'd1;
                        if (ecnt >= 5'(DATA_FIRST_EDGE - 1))
                            rx <= {rx[RX_W-2:0], miso};
                    end
                    // last high phase ends a cycle early so cs_n can rise alone
                    if (pre_fall && ecnt == 5'(N_EDGES)) sck <= 1'b0;
                    if (fall) begin
                        sck <= 1'b0;
                        if (ecnt == 5'(N_EDGES)) begin
                            cs_n        <= 1'b1;
                            mosi        <= 1'b0;
                            rsp_valid   <= 1'b1;
                            rsp_data    <= rx[RX_W-1:ERR_W];
                            rsp_err_idx <= rx[ERR_W-1:0];
                            rsp_err     <= |rx[ERR_W-1:0];
                            state       <= DONE;
                        end else if (ecnt >= 5'(ADDR_FIRST_EDGE - 1) &&
                                     ecnt <  5'(ADDR_FIRST_EDGE - 1 + ADDR_W)) begin
                            mosi    <= addr_sh[ADDR_W-1];
                            addr_sh <= {addr_sh[ADDR_W-2:0], 1'b0};
                        end else begin
                            mosi <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_rd_master.sv
// Bench for spi_rd_master: two instances (CLK_DIV 4 and 2), each with a
// behavioural SPI responder and a response scoreboard.
module tb_spi_rd_master;
    import spi_rd_pkg::*;

    typedef struct {
        logic [4:0]  addr;
        logic [20:0] word;
        int          acc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_rd_master_if rif0 ();
    spi_rd_master_if rif1 ();
    logic sck0, cs0, mosi0, sck1, cs1, mosi1;
    logic miso0 = 1'b0;
    logic miso1 = 1'b0;

    spi_rd_master #(.CLK_DIV(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .rif(rif0), .sck(sck0), .cs_n(cs0), .mosi(mosi0), .miso(miso0));
    spi_rd_master #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .rif(rif1), .sck(sck1), .cs_n(cs1), .mosi(mosi1), .miso(miso1));

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    exp_t sb0[$];
    exp_t sb1[$];
    int   n_acc[2], last_acc[2], hi_cnt[2], lo_cnt[2], seq_bad[2], e_cnt[2];
    logic psck[2], pcs[2], mbad[2];
    logic [4:0] rx_a[2];
    int   b2b_on = 0;
    int   b2b_n  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Responder ROM: decoded payload and Hamming error index per address.
    function automatic logic [20:0] rom(input logic [4:0] a);
        case (a)
            5'd22:   rom = {16'hA5C3, 5'd0};
            5'd9:    rom = {16'h3C96, 5'd13};
            default: rom = {a, ~a, a, 1'b1, 5'd0};
        endcase
    endfunction

    function automatic int div_of(input int k);
        return (k == 0) ? 4 : 2;
    endfunction

    // Responder: samples mosi on sck rise, drives sdo on sck rise.
    task automatic resp_edge(input int k, input logic cs, input logic mo, output logic so);
        logic [20:0] w;
        so = 1'b0;
        if (cs) begin
            e_cnt[k] = 0;
        end else begin
            e_cnt[k]++;
            if (e_cnt[k] >= 2 && e_cnt[k] <= 6) rx_a[k] = {rx_a[k][3:0], mo};
            else if (mo) mbad[k] = 1'b1;
            if (e_cnt[k] >= 8 && e_cnt[k] <= 28) begin
                w  = rom(rx_a[k]);
                so = w[28 - e_cnt[k]];
            end
        end
    endtask

    always @(posedge sck0) resp_edge(0, cs0, mosi0, miso0);
    always @(posedge sck1) resp_edge(1, cs1, mosi1, miso1);

    task automatic acc(input int k, input logic fire, input logic [4:0] a);
        exp_t x;
        if (fire) begin
            x.addr = a;
            x.word = rom(a);
            x.acc  = cyc;
            if (k == 0) sb0.push_back(x);
            else        sb1.push_back(x);
            if (k == 0 && b2b_on != 0) begin
                if (b2b_n > 0) chk("b2b_gap", cyc - last_acc[0], 60 * 4 + 2);
                b2b_n++;
            end
            n_acc[k]++;
            last_acc[k] = cyc;
            hi_cnt[k]   = 0;
            lo_cnt[k]   = 0;
            seq_bad[k]  = 0;
            mbad[k]     = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        cyc++;
        acc(0, rif0.req_valid && rif0.req_ready, rif0.req_addr);
        acc(1, rif1.req_valid && rif1.req_ready, rif1.req_addr);
    end

    task automatic mon(input int k, input logic s, input logic c, input logic rv,
                       input logic [15:0] d, input logic [4:0] ei, input logic er);
        exp_t x;
        int   qs;
        if (s && !psck[k]) begin
            if (c) hi_cnt[k]++;
            else   lo_cnt[k]++;
        end
        if (c != pcs[k] && (s != psck[k] || s)) seq_bad[k]++;
        psck[k] = s;
        pcs[k]  = c;
        if (rv) begin
            qs = (k == 0) ? sb0.size() : sb1.size();
            chk("rsp_pending", 32'(qs != 0), 32'd1);
            if (qs != 0) begin
                if (k == 0) x = sb0.pop_front();
                else        x = sb1.pop_front();
                chk("rsp_data",    32'(d),  32'(x.word[20:5]));
                chk("rsp_err_idx", 32'(ei), 32'(x.word[4:0]));
                chk("rsp_err",     32'(er), 32'(|x.word[4:0]));
                chk("rsp_latency", cyc - x.acc, 60 * div_of(k));
                chk("mosi_addr",   32'(rx_a[k]), 32'(x.addr));
                chk("mosi_idle",   32'(mbad[k]), 32'd0);
                chk("sck_edges_cs_hi", hi_cnt[k], 1);
                chk("sck_edges_cs_lo", lo_cnt[k], 29);
                chk("cs_sck_overlap",  seq_bad[k], 0);
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, sck0, cs0, rif0.rsp_valid, rif0.rsp_data, rif0.rsp_err_idx, rif0.rsp_err);
        mon(1, sck1, cs1, rif1.rsp_valid, rif1.rsp_data, rif1.rsp_err_idx, rif1.rsp_err);
    end

    // an aborted transfer never responds
    always @(negedge rst_n) begin
        sb0.delete();
        sb1.delete();
    end

    task automatic request(input int k, input logic [4:0] a);
        int n0;
        n0 = n_acc[k];
        if (k == 0) begin rif0.req_addr = a; rif0.req_valid = 1'b1; end
        else        begin rif1.req_addr = a; rif1.req_valid = 1'b1; end
        for (int i = 0; i < 50 && n_acc[k] == n0; i++) @(negedge clk);
        if (k == 0) rif0.req_valid = 1'b0;
        else        rif1.req_valid = 1'b0;
        chk("accept", n_acc[k] - n0, 1);
    endtask

    task automatic wait_idle(input int k);
        int qs;
        logic rdy;
        qs  = (k == 0) ? sb0.size() : sb1.size();
        rdy = (k == 0) ? rif0.req_ready : rif1.req_ready;
        for (int i = 0; i < 800 && (qs != 0 || !rdy); i++) begin
            @(negedge clk);
            qs  = (k == 0) ? sb0.size() : sb1.size();
            rdy = (k == 0) ? rif0.req_ready : rif1.req_ready;
        end
        chk("done_in_budget", qs, 0);
    endtask

    initial begin
        rif0.req_valid = 1'b0; rif0.req_addr = '0;
        rif1.req_valid = 1'b0; rif1.req_addr = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs_n",      32'(cs0), 32'd1);
        chk("rst_sck",       32'(sck0), 32'd0);
        chk("rst_mosi",      32'(mosi0), 32'd0);
        chk("rst_rsp_valid", 32'(rif0.rsp_valid), 32'd0);
        chk("rst_req_ready", 32'(rif0.req_ready), 32'd1);
        chk("rst_busy",      32'(rif0.busy), 32'd0);
        chk("rst_rsp_word",  32'({rif0.rsp_data, rif0.rsp_err_idx, rif0.rsp_err}), 32'd0);
        chk("rst_cs_n_div2", 32'(cs1), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        request(0, 5'b10110);
        wait_idle(0);
        request(0, 5'd9);
        wait_idle(0);

        // back-to-back with req_valid held high
        b2b_on = 1;
        b2b_n  = 0;
        rif0.req_addr  = 5'd3;
        rif0.req_valid = 1'b1;
        for (int i = 0; i < 50 && b2b_n < 1; i++) @(negedge clk);
        rif0.req_addr = 5'd28;
        for (int i = 0; i < 800 && b2b_n < 2; i++) @(negedge clk);
        rif0.req_valid = 1'b0;
        b2b_on = 0;
        chk("b2b_accepts", b2b_n, 2);
        wait_idle(0);

        // asynchronous reset in the middle of a transfer
        request(0, 5'd7);
        for (int i = 0; i < 400 && !(e_cnt[0] == 15 && sck0); i++) @(negedge clk);
        chk("reached_e15", e_cnt[0], 15);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cs_n",      32'(cs0), 32'd1);
        chk("arst_sck",       32'(sck0), 32'd0);
        chk("arst_rsp_valid", 32'(rif0.rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        request(0, 5'd7);
        wait_idle(0);

        // CLK_DIV = 2 instance
        request(1, 5'b10110);
        wait_idle(1);
        request(1, 5'd5);
        wait_idle(1);

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_rd_master.md
# spi_rd_master

SPI initiator that performs one protected-ROM read per request over the 4-wire link served by the team's SPI responder (spi_if_2 + h_ext). It accepts a 5-bit address from a valid/ready request port and generates SPI mode 0 from the system clock. It shifts the address out, then shifts in 16 data bits and the 5-bit Hamming error index. It returns both on a single-cycle response strobe.

## Interface
- CLK_DIV, default 4, clk cycles per sck half-period; legal range 2..255.
- clk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  read request.
- req_ready  out  1  high only in IDLE; a transfer is accepted on `req_valid && req_ready`.
- req_addr  in  5  ROM address; captured at accept.
- rsp_valid  out  1  one-cycle pulse; no backpressure.
- rsp_data  out  16  received data word; held until the next rsp_valid.
- rsp_err_idx  out  5  received error index; held until the next rsp_valid.
- rsp_err  out  1  `rsp_err_idx != 0`; registered with rsp_data.
- busy  out  1  `!req_ready`.
- sck  out  1  SPI clock; idles low.
- cs_n  out  1  chip select, active low.
- mosi  out  1  to the responder's sdi.
- miso  in  1  from the responder's sdo.

## Operation
- FSM states: IDLE, FLUSH, SHIFT, DONE.
- IDLE
  - cs_n=1, sck=0, mosi=0.
  - On accept: latch req_addr and go to FLUSH.
- FLUSH
  - cs_n=1 for one full sck period (low for CLK_DIV cycles, then high for CLK_DIV cycles).
  - This rising edge returns the responder's FSM to its idle state.
  - Then go to SHIFT.
- SHIFT
  - cs_n=0 for exactly 29 sck periods, each CLK_DIV low then CLK_DIV high.
  - Rising edges are numbered e=1..29.
  - mosi changes only at the start of a low phase.
  - Before e=2..6, mosi carries addr[4..0], MSB first.
  - mosi=0 before every other edge.
  - miso is sampled on the clk edge that raises sck. This captures the value the responder drove on the previous sck rising edge.
  - For e=9..29, each sample is shifted into a 21-bit register, MSB first.
  - Result: rx[20:5] = data[15:0], rx[4:0] = err_idx[4:0]. Samples at e≤8 are ignored.
- DONE
  - Lasts one cycle: cs_n=1, sck=0.
  - Load rsp_data, rsp_err_idx and rsp_err from rx.
  - rsp_valid=1, then go to IDLE.
- Counters
  - Half-period counter: 8 bits, counts 0..CLK_DIV-1.
  - Edge counter: 5 bits, counts 0..29; no wrap inside a transfer.
- req_valid is ignored outside IDLE.
- A request arriving in the DONE cycle is accepted in the following IDLE cycle.

## Timing
- Reset values: cs_n=1, sck=0, mosi=0, rsp_valid=0, rsp_data=0, rsp_err_idx=0, rsp_err=0, req_ready=1, busy=0.
- Reset applies asynchronously, including mid-transfer:
  - cs_n rises and sck falls without waiting for clk.
  - No rsp_valid is issued.
  - The responder is resynchronised by the next transfer's FLUSH.
- Accept happens at clk edge 0. Then:
  - FLUSH occupies cycles 1..2·CLK_DIV.
  - SHIFT occupies the next 58·CLK_DIV cycles.
  - rsp_valid is high in cycle 60·CLK_DIV+1, i.e. 241 for CLK_DIV=4.
- req_ready rises the cycle after rsp_valid. The minimum accept-to-accept interval is 60·CLK_DIV+2 cycles.
- Per transfer there are exactly 30 sck rising edges: 1 with cs_n=1, then 29 with cs_n=0.
- cs_n changes only while sck=0. A cs_n edge and an sck edge never occur in the same cycle.
- All SPI outputs are driven directly from flops, with no combinational path from miso.

## Structure
- Package spi_rd_pkg contains:
  - the state enum (IDLE, FLUSH, SHIFT, DONE);
  - ADDR_W=5, DATA_W=16, ERR_W=5;
  - N_EDGES=29, ADDR_FIRST_EDGE=2, DATA_FIRST_EDGE=9.
- Sub-module spi_sck_div:
  - holds the CLK_DIV half-period counter;
  - outputs one-cycle `rise` and `fall` ticks, with enable and clear inputs;
  - is instantiated once.
- FSM, address shifter and receive shifter live in spi_rd_master.

## Test plan
- Reset: hold rst_n=0 → cs_n=1, sck=0, mosi=0, rsp_valid=0, req_ready=1. Assert rst_n=0 asynchronously mid-cycle → outputs change before the next clk.
- Clean read, CLK_DIV=4, spi_if_2_h_top responder, addr 5'b10110, stored word has data 16'hA5C3 and no error:
  - mosi=1,0,1,1,0 at e=2..6;
  - rsp_data=16'hA5C3, rsp_err_idx=0, rsp_err=0;
  - rsp_valid in cycle 241.
- Single-bit error: flip codeword bit 13 of the stored word → rsp_err_idx=5'd13, rsp_err=1, rsp_data equals the raw payload bits of that codeword.
- Back-to-back: hold req_valid=1 with addr 3 then addr 28:
  - second accept occurs the cycle after the first rsp_valid;
  - second transfer starts with a cs_n=1 FLUSH edge;
  - both responses are correct.
- Reset mid-transfer: drop rst_n at e=15 → cs_n=1 and sck=0 immediately, and no rsp_valid. Next request for addr 7 returns the correct word.
- CLK_DIV=2: per transfer, count 1 sck rising edge with cs_n high and 29 with cs_n low; rsp_valid in cycle 121.
